// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding memory bus.
// Define MEMORY_ARBITER_TIMEOUT_EN (parameter TIMEOUT) to force-complete accesses that never see memory_ready.
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        timeout_err
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t      r_state;
    logic [1:0]  r_pend;
    logic        r_last;
    logic        r_owner;
    logic [1:0]  r_instr;
    logic [31:0] r_addr  [2];
    logic [31:0] r_wdata [2];
    logic [3:0]  r_wstrb [2];
    logic        r_mem_valid;
    logic        r_mem_instr;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic [3:0]  r_mem_wstrb;

    logic [1:0]  w_in_valid;
    logic [1:0]  w_in_instr;
    logic [31:0] w_in_addr  [2];
    logic [31:0] w_in_wdata [2];
    logic [3:0]  w_in_wstrb [2];
    logic        w_expire;
    logic        w_done;
    logic [1:0]  w_done_port;
    logic [1:0]  w_capture;
    logic        w_issue;
    logic        w_issue_port;

    assign w_in_valid    = {m1_valid, m0_valid};
    assign w_in_instr    = {m1_instr, m0_instr};
    assign w_in_addr[0]  = m0_addr;
    assign w_in_addr[1]  = m1_addr;
    assign w_in_wdata[0] = m0_wdata;
    assign w_in_wdata[1] = m1_wdata;
    assign w_in_wstrb[0] = m0_wstrb;
    assign w_in_wstrb[1] = m1_wstrb;

    // Completion, capture acceptance and next-grant selection.
    always_comb begin
        w_done       = 1'b0;
        w_issue      = 1'b0;
        w_issue_port = 1'b0;
        if (r_state == ST_WAIT) begin
            w_done = memory_ready | w_expire;
        end else begin
            w_done = 1'b0;
        end
        w_done_port = {w_done & r_owner, w_done & ~r_owner};
        // A completing port may accept its next request in the same cycle.
        w_capture   = w_in_valid & (~r_pend | w_done_port);
        case (r_state)
            ST_IDLE: begin
                w_issue      = |r_pend;
                w_issue_port = (r_pend == 2'b11) ? ~r_last : r_pend[1];
            end
            ST_WAIT: begin
                w_issue      = w_done & r_pend[~r_owner];
                w_issue_port = ~r_owner;
            end
            default: begin
                w_issue      = 1'b0;
                w_issue_port = 1'b0;
            end
        endcase
    end

    // Per-port pending request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= 2'b00;
            r_instr <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_addr[i]  <= 32'h0;
                r_wdata[i] <= 32'h0;
                r_wstrb[i] <= 4'h0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_capture[i]) begin
                    r_pend[i]  <= 1'b1;
                    r_instr[i] <= w_in_instr[i];
                    r_addr[i]  <= w_in_addr[i];
                    r_wdata[i] <= w_in_wdata[i];
                    r_wstrb[i] <= w_in_wstrb[i];
                end else if (w_done_port[i]) begin
                    r_pend[i] <= 1'b0;
                end
            end
        end
    end

    // Arbitration FSM with registered downstream request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_instr <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_wstrb <= 4'h0;
        end else begin
            r_mem_valid <= w_issue;
            if (w_issue) begin
                r_owner     <= w_issue_port;
                r_mem_instr <= r_instr[w_issue_port];
                r_mem_addr  <= r_addr[w_issue_port];
                r_mem_wdata <= r_wdata[w_issue_port];
                r_mem_wstrb <= r_wstrb[w_issue_port];
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_done) begin
                        r_last <= r_owner;
                        if (!w_issue) r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;

    // memory_ready arriving in the expiry cycle wins, so no error is flagged.
    assign w_expire    = (r_state == ST_WAIT) && (r_tmo_cnt == CNT_W'(TIMEOUT)) && !memory_ready;
    assign timeout_err = r_timeout_err;

    // Watchdog counter restarted by every issue; sticky error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
            end
            if (w_expire) r_timeout_err <= 1'b1;
        end
    end
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign memory_valid = r_mem_valid;
    assign memory_instr = r_mem_instr;
    assign memory_addr  = r_mem_addr;
    assign memory_wdata = r_mem_wdata;
    assign memory_wstrb = r_mem_wstrb;
    assign m0_ready     = w_done_port[0];
    assign m1_ready     = w_done_port[1];
    // A forced (timeout) completion returns zero data.
    assign m0_rdata     = (w_done_port[0] & memory_ready) ? memory_rdata : 32'h0;
    assign m1_rdata     = (w_done_port[1] & memory_ready) ? memory_rdata : 32'h0;
endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: vector table, directed corner sequences and random traffic vs. a request-queue model.
module tb_memory_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic        memory_valid, memory_instr, memory_ready, timeout_err;
    logic [31:0] memory_addr, memory_wdata, memory_rdata;
    logic [3:0]  memory_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    memory_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
        .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .timeout_err(timeout_err)
    );

    typedef struct {
        logic        port;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          delay;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
        memory_ready = 1'b0; memory_rdata = 32'h0;
    endtask

    task automatic req(input logic p, input logic ins, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        if (p) begin
            m1_valid = 1'b1; m1_instr = ins; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
        end else begin
            m0_valid = 1'b1; m0_instr = ins; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
        end
    endtask

    // Reset across one rising edge; returns in cycle 0 after release.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mvalid"}, memory_valid, 1'b0);
        chk({tag, "_mfields"}, {memory_instr, memory_addr, memory_wdata, memory_wstrb}, 69'h0);
        chk({tag, "_readies"}, {m0_ready, m1_ready}, 2'b00);
        chk({tag, "_rdatas"}, {m0_rdata, m1_rdata}, 64'h0);
        chk({tag, "_terr"}, timeout_err, 1'b0);
    endtask

    // Both ports request together; expect port `first` issued, then the other right after its completion.
    task automatic tie_round(input logic first, input logic [31:0] a0, input logic [31:0] a1);
        logic [31:0] exp_first;
        logic [31:0] exp_second;
        exp_first  = first ? a1 : a0;
        exp_second = first ? a0 : a1;
        req(1'b0, 1'b0, a0, 32'h0, 4'h0);
        req(1'b1, 1'b0, a1, 32'h0, 4'h0);
        tick(); idle_inputs(); #1;
        tick(); #1;
        chk("tie_first_valid", memory_valid, 1'b1);
        chk("tie_first_addr", memory_addr, exp_first);
        tick(); memory_ready = 1'b1; memory_rdata = 32'h1111_0000; #1;
        chk("tie_first_ready", {m1_ready, m0_ready}, first ? 2'b10 : 2'b01);
        tick(); idle_inputs(); #1;
        chk("tie_second_valid", memory_valid, 1'b1);
        chk("tie_second_addr", memory_addr, exp_second);
        tick(); memory_ready = 1'b1; memory_rdata = 32'h2222_0000; #1;
        chk("tie_second_ready", {m1_ready, m0_ready}, first ? 2'b01 : 2'b10);
        chk("tie_second_rdata", first ? m0_rdata : m1_rdata, 32'h2222_0000);
        tick(); idle_inputs(); #1;
        chk("tie_after_valid", memory_valid, 1'b0);
    endtask

    // Model state for random traffic: one-deep request queue per port plus bus ownership.
    logic        q_full [2];
    logic [68:0] q_req  [2];
    int          inflight, issue_next, last_done, wait_left;

    task automatic random_traffic(input int n_cycles);
        logic [1:0]  v;
        logic [68:0] f [2];
        int          issuing, done;
        logic        exp_r0, exp_r1;
        q_full[0] = 1'b0; q_full[1] = 1'b0;
        inflight = -1; issue_next = -1; last_done = 1; wait_left = 0;
        for (int c = 0; c < n_cycles; c++) begin
            issuing = issue_next;
            if (issuing >= 0) begin
                inflight  = issuing;
                wait_left = $urandom_range(0, 3);
            end
            for (int p = 0; p < 2; p++) begin
                v[p] = ($urandom_range(0, 2) == 0);
                f[p] = {$urandom_range(0, 1) == 1, $urandom, $urandom, 4'($urandom_range(0, 15))};
            end
            m0_valid = v[0]; {m0_instr, m0_addr, m0_wdata, m0_wstrb} = f[0];
            m1_valid = v[1]; {m1_instr, m1_addr, m1_wdata, m1_wstrb} = f[1];
            memory_rdata = $urandom;
            if (inflight >= 0) begin
                memory_ready = (wait_left == 0);
                if (wait_left > 0) wait_left--;
            end else begin
                memory_ready = ($urandom_range(0, 7) == 0);
            end
            #1;
            chk("rnd_mvalid", memory_valid, issuing >= 0);
            if (issuing >= 0)
                chk("rnd_fields", {memory_instr, memory_addr, memory_wdata, memory_wstrb}, q_req[issuing]);
            exp_r0 = (inflight == 0) && memory_ready;
            exp_r1 = (inflight == 1) && memory_ready;
            chk("rnd_ready", {m1_ready, m0_ready}, {exp_r1, exp_r0});
            chk("rnd_rdata0", m0_rdata, exp_r0 ? memory_rdata : 32'h0);
            chk("rnd_rdata1", m1_rdata, exp_r1 ? memory_rdata : 32'h0);
            chk("rnd_terr", timeout_err, 1'b0);
            done = -1;
            issue_next = -1;
            if (inflight >= 0 && memory_ready) done = inflight;
            if (done >= 0) begin
                if (q_full[1 - done]) issue_next = 1 - done;
                q_full[done] = 1'b0;
                last_done = done;
                inflight = -1;
            end else if (inflight < 0) begin
                if (q_full[0] && q_full[1]) issue_next = 1 - last_done;
                else if (q_full[0]) issue_next = 0;
                else if (q_full[1]) issue_next = 1;
            end
            for (int p = 0; p < 2; p++) begin
                if (v[p] && !q_full[p]) begin
                    q_full[p] = 1'b1;
                    q_req[p]  = f[p];
                end
            end
            tick();
        end
        idle_inputs();
        for (int k = 0; k < 8; k++) begin
            memory_ready = 1'b1;
            tick();
        end
        idle_inputs();
    endtask

    vec_t vecs [4];

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b0, 32'h0200_4000, 32'h1234_5678, 4'hF, 32'h0000_00AA, 1, 32'h0000_00AA};
        vecs[2] = '{1'b0, 1'b1, 32'h0000_1004, 32'hCAFE_F00D, 4'h0, 32'h1357_9BDF, 5, 32'h1357_9BDF};
        vecs[3] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h3, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF};

        idle_inputs();
        rst = 1'b1;
        #1;
        chk_reset_outputs("reset");
        tick();
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            tick();
            req(vecs[v].port, vecs[v].instr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb);
            #1;
            tick(); idle_inputs(); #1;
            chk("vec_c1_valid", memory_valid, 1'b0);
            tick(); #1;
            chk("vec_issue_valid", memory_valid, 1'b1);
            chk("vec_issue_fields", {memory_instr, memory_addr, memory_wdata, memory_wstrb},
                {vecs[v].instr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb});
            for (int d = 1; d < vecs[v].delay; d++) begin
                tick(); #1;
                chk("vec_wait", {memory_valid, m0_ready, m1_ready}, 3'b000);
            end
            tick(); memory_ready = 1'b1; memory_rdata = vecs[v].rdata; #1;
            chk("vec_ready", {m1_ready, m0_ready}, vecs[v].port ? 2'b10 : 2'b01);
            chk("vec_rdata", vecs[v].port ? m1_rdata : m0_rdata, vecs[v].exp_rdata);
            chk("vec_other_rdata", vecs[v].port ? m0_rdata : m1_rdata, 32'h0);
            tick(); idle_inputs(); #1;
            chk("vec_after", {memory_valid, m0_ready, m1_ready}, 3'b000);
        end

        // Simultaneous requests from reset: port 0 first, then alternation.
        do_reset();
        tie_round(1'b0, 32'hA000_0000, 32'hB000_0000);
        tick();
        tie_round(1'b0, 32'hA000_0004, 32'hB000_0004);

        // Reset in the middle of WAIT abandons the access.
        do_reset();
        req(1'b0, 1'b1, 32'h8000_0020, 32'h5555_AAAA, 4'h5);
        tick(); idle_inputs(); #1;
        tick(); #1;
        chk("rstwait_issue", memory_valid, 1'b1);
        tick(); rst = 1'b1; #1;
        chk_reset_outputs("rstwait_in_rst");
        tick(); rst = 1'b0; memory_ready = 1'b1; memory_rdata = 32'h7777_7777; #1;
        chk("rstwait_late_ready", {m0_ready, m1_ready}, 2'b00);
        chk("rstwait_late_rdata", m0_rdata, 32'h0);
        tick(); idle_inputs(); req(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); #1;
        chk("rstwait_next_c1", memory_valid, 1'b0);
        tick(); #1;
        chk("rstwait_next_issue", {memory_valid, memory_addr}, {1'b1, 32'h0000_0040});
        tick(); memory_ready = 1'b1; #1;
        chk("rstwait_next_ready", m1_ready, 1'b1);
        tick(); idle_inputs();

        // Re-request in the completion cycle is captured; a request while pending is dropped.
        req(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); #1;
        tick(); #1;
        chk("rereq_issue1", memory_addr, 32'h0000_0100);
        tick(); #1;
        tick(); memory_ready = 1'b1; req(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0); #1;
        chk("rereq_ready1", m0_ready, 1'b1);
        tick(); idle_inputs(); #1;
        chk("rereq_gap", memory_valid, 1'b0);
        tick(); #1;
        chk("rereq_issue2", {memory_valid, memory_addr}, {1'b1, 32'h0000_0200});
        tick(); memory_ready = 1'b1; #1;
        chk("rereq_ready2", m0_ready, 1'b1);
        tick(); idle_inputs();
        req(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); req(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); #1;
        chk("drop_issue", {memory_valid, memory_addr}, {1'b1, 32'h0000_0300});
        tick(); memory_ready = 1'b1; #1;
        chk("drop_ready", m0_ready, 1'b1);
        tick(); idle_inputs();
        begin
            int extra;
            extra = 0;
            for (int k = 0; k < 6; k++) begin
                memory_ready = 1'b1; #1;
                extra += int'(memory_valid) + int'(m0_ready);
                tick();
            end
            idle_inputs();
            chk("drop_no_second", extra, 0);
        end

`ifdef MEMORY_ARBITER_TIMEOUT_EN
        // memory_ready exactly at expiry takes priority; then a true expiry.
        do_reset();
        req(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); #1;
        tick(); #1;
        chk("tmo_prio_issue", memory_valid, 1'b1);
        for (int k = 3; k < 18; k++) begin
            tick(); #1;
        end
        tick(); memory_ready = 1'b1; memory_rdata = 32'hA5A5_5A5A; #1;
        chk("tmo_prio_rdata", {m0_ready, m0_rdata}, {1'b1, 32'hA5A5_5A5A});
        tick(); idle_inputs(); #1;
        chk("tmo_prio_noerr", timeout_err, 1'b0);
        req(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); #1;
        tick(); #1;
        chk("tmo_issue", memory_valid, 1'b1);
        for (int k = 3; k < 18; k++) begin
            tick(); memory_rdata = 32'hFFFF_0000; #1;
            chk("tmo_early", m0_ready, 1'b0);
        end
        tick(); #1;
        chk("tmo_expire", {m0_ready, m0_rdata, m1_ready}, {1'b1, 32'h0, 1'b0});
        chk("tmo_err_not_yet", timeout_err, 1'b0);
        tick(); memory_ready = 1'b1; #1;
        chk("tmo_err_set", timeout_err, 1'b1);
        chk("tmo_late_ignored", m0_ready, 1'b0);
        tick(); idle_inputs(); tick(); tick(); #1;
        chk("tmo_err_sticky", timeout_err, 1'b1);
        do_reset(); #1;
        chk("tmo_err_cleared", timeout_err, 1'b0);
`else
        // Without the watchdog the bus waits indefinitely.
        do_reset();
        req(1'b0, 1'b0, 32'h0000_0700, 32'h0, 4'h0); #1;
        tick(); idle_inputs(); #1;
        tick(); #1;
        chk("notmo_issue", memory_valid, 1'b1);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 40; k++) begin
                tick(); #1;
                seen += int'(m0_ready) + int'(timeout_err);
            end
            chk("notmo_waits", seen, 0);
        end
        tick(); memory_ready = 1'b1; memory_rdata = 32'h0BAD_CAFE; #1;
        chk("notmo_ready", {m0_ready, m0_rdata}, {1'b1, 32'h0BAD_CAFE});
        tick(); idle_inputs();
`endif

        do_reset();
        random_traffic(3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
